// File: rtl/ex_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: single-cycle multiply, radix-2 restoring divide.
// Stalls the front of the pipeline through busy_out and returns result with rd on a done pulse.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int INDEX = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             flush_in,
    input  logic [2:0]       funct3_in,
    input  logic [INDEX-1:0] rd_in,
    input  logic [WIDTH-1:0] drs1_in,
    input  logic [WIDTH-1:0] drs2_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [INDEX-1:0] rd_out,
    output logic [WIDTH-1:0] result_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state, state_next;
    logic [1:0]       funct3_q;
    logic [INDEX-1:0] rd_q;
    logic [WIDTH-1:0] op_a;      // multiplicand, or dividend magnitude shifting into quotient
    logic [WIDTH-1:0] op_b;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    counter;
    logic             neg_quo, neg_rem;

    // Decode of the op presented by ID/EX
    logic             accept, is_div, div_signed, div_zero, div_ovf, div_special;
    logic [WIDTH-1:0] special_result, mag_a, mag_b;

    assign accept      = start_in && !flush_in && (state == S_IDLE || state == S_DONE);
    assign is_div      = funct3_in[2];
    assign div_signed  = !funct3_in[0];
    assign div_zero    = (drs2_in == '0);
    assign div_ovf     = div_signed && (drs1_in == MIN_INT) && (drs2_in == '1);
    assign div_special = div_zero || div_ovf;
    assign mag_a       = (div_signed && drs1_in[WIDTH-1]) ? -drs1_in : drs1_in;
    assign mag_b       = (div_signed && drs2_in[WIDTH-1]) ? -drs2_in : drs2_in;

    always_comb begin
        if (div_zero) special_result = funct3_in[1] ? drs1_in : '1;
        else          special_result = funct3_in[1] ? '0 : MIN_INT;
    end

    // Multiplier: MULH and MULHSU treat rs1 as signed, only MULH treats rs2 as signed
    logic signed [WIDTH:0]     ext_a, ext_b;
    logic signed [2*WIDTH-1:0] prod;

    assign ext_a = {(funct3_q == 2'b01 || funct3_q == 2'b10) && op_a[WIDTH-1], op_a};
    assign ext_b = {(funct3_q == 2'b01) && op_b[WIDTH-1], op_b};
    assign prod  = ext_a * ext_b;

    // One restoring-division step
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_next, quo_next, quo_fix, rem_fix;

    assign shifted  = {rem, op_a[WIDTH-1]};
    assign diff     = shifted - {1'b0, op_b};
    assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {op_a[WIDTH-2:0], ~diff[WIDTH]};
    assign quo_fix  = neg_quo ? -quo_next : quo_next;
    assign rem_fix  = neg_rem ? -rem_next : rem_next;

    assign busy_out = (state == S_MUL) || (state == S_DIV) || accept;
    assign done_out = (state == S_DONE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept)                      state_next = !is_div ? S_MUL : (div_special ? S_DONE : S_DIV);
                else if (state == S_DONE)        state_next = S_IDLE;
            end
            S_MUL:                               state_next = S_DONE;
            S_DIV: if (counter == '0)            state_next = S_DONE;
            default:                             state_next = S_IDLE;
        endcase
        if (flush_in) state_next = S_IDLE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            funct3_q   <= '0;
            rd_q       <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rem        <= '0;
            counter    <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            rd_out     <= '0;
            result_out <= '0;
        end else if (flush_in) begin
            counter <= '0;
        end else if (accept) begin
            funct3_q <= funct3_in[1:0];
            rd_q     <= rd_in;
            rem      <= '0;
            counter  <= CW'(WIDTH - 1);
            neg_quo  <= div_signed && (drs1_in[WIDTH-1] ^ drs2_in[WIDTH-1]);
            neg_rem  <= div_signed && drs1_in[WIDTH-1];
            op_a     <= is_div ? mag_a : drs1_in;
            op_b     <= is_div ? mag_b : drs2_in;
            if (is_div && div_special) begin
                rd_out     <= rd_in;
                result_out <= special_result;
            end
        end else if (state == S_MUL) begin
            rd_out     <= rd_q;
            result_out <= (funct3_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end else if (state == S_DIV) begin
            op_a <= quo_next;
            rem  <= rem_next;
            if (counter == '0) begin
                rd_out     <= rd_q;
                result_out <= funct3_q[1] ? rem_fix : quo_fix;
            end else begin
                counter <= counter - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit: results, latency, busy/done timing, flush, reset, back-to-back.
module tb_ex_muldiv_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic        flush_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic [31:0] drs1_in;
    logic [31:0] drs2_in;
    logic        busy_out;
    logic        done_out;
    logic [4:0]  rd_out;
    logic [31:0] result_out;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    ex_muldiv_unit #(.WIDTH(32), .INDEX(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .flush_in(flush_in),
        .funct3_in(funct3_in), .rd_in(rd_in), .drs1_in(drs1_in), .drs2_in(drs2_in),
        .busy_out(busy_out), .done_out(done_out), .rd_out(rd_out), .result_out(result_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic present(input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
        start_in  = 1'b1;
        funct3_in = f3;
        rd_in     = rd;
        drs1_in   = a;
        drs2_in   = b;
    endtask

    // Issue one op at cycle 0, then watch done/busy up to cycle lat+1.
    task automatic run_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat, input string name);
        int first = -1;
        int pulses = 0;
        int busy_bad = 0;
        @(negedge clk_in);
        present(f3, rd, a, b);
        #1 if (busy_out !== 1'b1) busy_bad++;
        @(posedge clk_in);
        #1 start_in = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk_in);
            if (done_out === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (busy_out !== (c < lat)) busy_bad++;
        end
        checks += 5;
        if (result_out !== exp) begin
            errors++; $display("FAIL %s result: got %h expected %h", name, result_out, exp);
        end
        if (rd_out !== rd) begin
            errors++; $display("FAIL %s rd: got %0d expected %0d", name, rd_out, rd);
        end
        if (first !== lat) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, first, lat);
        end
        if (pulses !== 1) begin
            errors++; $display("FAIL %s done pulses: got %0d expected 1", name, pulses);
        end
        if (busy_bad !== 0) begin
            errors++; $display("FAIL %s busy timing: %0d bad cycles expected 0", name, busy_bad);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0 || rd_out !== 5'd0 || result_out !== 32'd0) begin
            errors++;
            $display("FAIL %s: got busy=%b done=%b rd=%0d result=%h expected all zero",
                     name, busy_out, done_out, rd_out, result_out);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; start_in = 1'b0; flush_in = 1'b0;
        funct3_in = '0; rd_in = '0; drs1_in = '0; drs2_in = '0;
        #12 check_zero_outputs("reset_state");
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic test_mul();
        run_op(F_MUL,    5'd1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul");
        run_op(F_MULH,   5'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulh");
        run_op(F_MULHU,  5'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulhu");
        run_op(F_MULHSU, 5'd4, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2, "mulhsu");
        run_op(F_MULHU,  5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu_max");
    endtask

    task automatic test_div();
        run_op(F_DIV,  5'd6,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_neg");
        run_op(F_REM,  5'd7,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_neg");
        run_op(F_DIVU, 5'd8,  32'd100,       32'd7,         32'd14,        33, "divu");
        run_op(F_REMU, 5'd9,  32'd100,       32'd7,         32'd2,         33, "remu");
        run_op(F_DIV,  5'd10, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, "div_negdivisor");
        run_op(F_REM,  5'd11, 32'd20,        32'hFFFF_FFFD, 32'd2,         33, "rem_negdivisor");
    endtask

    task automatic test_div_special();
        run_op(F_DIVU, 5'd12, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by_zero");
        run_op(F_REM,  5'd13, 32'd5,         32'd0,         32'd5,         1, "rem_by_zero");
        run_op(F_DIV,  5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow");
        run_op(F_REM,  5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_overflow");
    endtask

    task automatic test_flush();
        int pulses = 0;
        logic [31:0] held;
        held = result_out;
        @(negedge clk_in);
        present(F_DIVU, 5'd16, 32'd1000, 32'd3);
        @(posedge clk_in);
        #1 start_in = 1'b0;
        repeat (9) @(posedge clk_in);
        #1 flush_in = 1'b1;
        @(posedge clk_in);
        #1 flush_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL flush busy: got %b expected 0", busy_out);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (done_out === 1'b1) pulses++;
        end
        checks += 2;
        if (pulses !== 0) begin
            errors++; $display("FAIL flush done pulses: got %0d expected 0", pulses);
        end
        if (result_out !== held) begin
            errors++; $display("FAIL flush result held: got %h expected %h", result_out, held);
        end
        // flush together with start: op must not be accepted
        @(negedge clk_in);
        present(F_MUL, 5'd17, 32'd3, 32'd3);
        flush_in = 1'b1;
        #1 checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL flush_with_start busy: got %b expected 0", busy_out);
        end
        @(posedge clk_in);
        #1 start_in = 1'b0; flush_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            errors++; $display("FAIL flush_with_start state: got busy=%b done=%b expected 0 0", busy_out, done_out);
        end
        run_op(F_MUL, 5'd18, 32'd6, 32'd9, 32'd54, 2, "mul_after_flush");
    endtask

    task automatic test_back_to_back();
        int first = -1;
        @(negedge clk_in);
        present(F_MUL, 5'd3, 32'd12, 32'd11);
        @(posedge clk_in);
        #1 start_in = 1'b0;
        @(posedge clk_in);
        #1 present(F_DIV, 5'd4, 32'hFFFF_FF9C, 32'd7);
        @(negedge clk_in);
        checks += 4;
        if (done_out !== 1'b1) begin
            errors++; $display("FAIL b2b mul done: got %b expected 1", done_out);
        end
        if (result_out !== 32'd132) begin
            errors++; $display("FAIL b2b mul result: got %h expected %h", result_out, 32'd132);
        end
        if (rd_out !== 5'd3) begin
            errors++; $display("FAIL b2b mul rd: got %0d expected 3", rd_out);
        end
        if (busy_out !== 1'b1) begin
            errors++; $display("FAIL b2b accept busy: got %b expected 1", busy_out);
        end
        @(posedge clk_in);
        #1 start_in = 1'b0;
        for (int c = 1; c <= 40 && first < 0; c++) begin
            @(negedge clk_in);
            if (done_out === 1'b1) first = c;
        end
        checks += 3;
        if (first !== 33) begin
            errors++; $display("FAIL b2b div latency: got %0d expected 33", first);
        end
        // -100 / 7 = -14
        if (result_out !== 32'hFFFF_FFF2) begin
            errors++; $display("FAIL b2b div result: got %h expected %h", result_out, 32'hFFFF_FFF2);
        end
        if (rd_out !== 5'd4) begin
            errors++; $display("FAIL b2b div rd: got %0d expected 4", rd_out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk_in);
        present(F_DIVU, 5'd20, 32'd77, 32'd5);
        @(posedge clk_in);
        #1 start_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1 check_zero_outputs("async_reset_mid_div");
        @(negedge clk_in);
        rst_in = 1'b0;
        run_op(F_REMU, 5'd21, 32'd77, 32'd5, 32'd2, 33, "remu_after_reset");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
